// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one request/ack transaction at a time.
// Grant on the edge a request is seen in IDLE, valid pulses the cycle after mem_ack, and stall freezes the PC until both requesters are served.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              timeout_err_q, timeout_err_d;

    logic              grant;
    logic              done;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        if_valid_d    = 1'b0;
        d_valid_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        grant         = GNT_FETCH;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    // On a tie the requester that lost last time wins, so neither port starves.
                    if (if_req && d_req) begin
                        grant = ~last_grant_q;
                    end else if (d_req) begin
                        grant = GNT_DATA;
                    end else begin
                        grant = GNT_FETCH;
                    end
                    last_grant_d = grant;
                    mem_req_d    = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = ST_XFER;
                    if (grant == GNT_DATA) begin
                        mem_addr_d  = d_addr;
                        mem_we_d    = d_we;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                    end
                end
            end

            ST_XFER: begin
                // last_grant_q holds the owner of the transaction in flight.
                if (mem_ack) begin
                    done = 1'b1;
                    if (last_grant_q == GNT_FETCH) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    done          = 1'b1;
                    timeout_err_d = 1'b1;
                    if (last_grant_q == GNT_FETCH) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end

                if (done) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = ST_RESP;
                    if_valid_d = (last_grant_q == GNT_FETCH);
                    d_valid_d  = (last_grant_q == GNT_DATA);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GNT_FETCH;
            cnt_q         <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_valid_q    <= 1'b0;
            d_valid_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            if_valid_q    <= if_valid_d;
            d_valid_q     <= d_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_valid    = if_valid_q;
    assign d_rdata     = d_rdata_q;
    assign d_valid     = d_valid_q;
    assign timeout_err = timeout_err_q;

    // Combinational so the PC freezes in the same cycle a request is raised.
    assign stall = (if_req & ~if_valid_q) | (d_req & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          CLK = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0040;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_cmp++;
        if ({mem_req, mem_we, if_valid, d_valid, timeout_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_valid, d_valid, timeout_err});
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got if=%h d=%h want 0/0", if_rdata, d_rdata);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: got req=%b addr=%h we=%b want 1/00000040/0", mem_req, mem_addr, mem_we);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h1111_2222) begin
            n_bad++; $display("FAIL reset_first_fetch: got v=%b rd=%h want 1/11112222", if_valid, if_rdata);
        end
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        if_addr = 32'h0000_0008; if_req = 1'b1; mem_rdata = '0;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8 || mem_we !== 1'b0) begin
            n_bad++; $display("FAIL fetch_grant: got req=%b addr=%h we=%b want 1/00000008/0", mem_req, mem_addr, mem_we);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (stall !== 1'b1 || if_valid !== 1'b0 || mem_req !== 1'b1) begin
                n_bad++; $display("FAIL fetch_wait%0d: got stall=%b v=%b req=%b want 1/0/1", i, stall, if_valid, mem_req);
            end
            if (i == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'hE3A0_1005;
            end
            tick();
        end
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== 32'hE3A0_1005 || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++; $display("FAIL fetch_done: got v=%b rd=%h stall=%b req=%b want 1/e3a01005/0/0", if_valid, if_rdata, stall, mem_req);
        end
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        n_cmp++;
        if (if_valid !== 1'b0 || stall !== 1'b0 || if_rdata !== 32'hE3A0_1005) begin
            n_bad++; $display("FAIL fetch_pulse: got v=%b stall=%b rd=%h want 0/0/e3a01005", if_valid, stall, if_rdata);
        end
    endtask

    task automatic test_tie_round_robin();
        bit exp_order [3];
        logic [31:0] exp_a;
        exp_order = '{1'b1, 1'b0, 1'b1};
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        if_req = 1'b1; if_addr = 32'h0000_000C;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL tie_data_first: got req=%b we=%b addr=%h wd=%h want 1/1/00000100/deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        n_cmp++;
        if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL tie_store_done: got dv=%b iv=%b drd=%h want 1/0/0", d_valid, if_valid, d_rdata);
        end
        d_req = 1'b0; mem_ack = 1'b0;
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || d_valid !== 1'b0) begin
            n_bad++; $display("FAIL tie_turnaround: got req=%b dv=%b want 0/0", mem_req, d_valid);
        end
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'hC) begin
            n_bad++; $display("FAIL tie_fetch_second: got req=%b we=%b addr=%h want 1/0/0000000c", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        tick();
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE_0001 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL tie_fetch_done: got iv=%b ird=%h drd=%h want 1/cafe0001/0", if_valid, if_rdata, d_rdata);
        end
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Three back-to-back ties: the winner re-raises in IDLE while the loser keeps waiting.
        if_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            exp_a = exp_order[t] ? 32'h20 : 32'h10;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== exp_a) begin
                n_bad++; $display("FAIL rr_grant%0d: got req=%b addr=%h want 1/%h", t, mem_req, mem_addr, exp_a);
            end
            mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(t);
            tick();
            n_cmp++;
            if (d_valid !== exp_order[t] || if_valid !== !exp_order[t]) begin
                n_bad++; $display("FAIL rr_valid%0d: got dv=%b iv=%b want %b/%b", t, d_valid, if_valid, exp_order[t], !exp_order[t]);
            end
            mem_ack = 1'b0;
            if (t == 2) begin
                if_req = 1'b0; d_req = 1'b0;
            end else if (exp_order[t]) begin
                d_req = 1'b0;
            end else begin
                if_req = 1'b0;
            end
            tick();
            if (t != 2) begin
                if (exp_order[t]) d_req = 1'b1;
                else if_req = 1'b1;
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++; $display("FAIL deadline_hold: got req=%b want 1", mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        n_cmp++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h5555_AAAA || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL deadline_ack_wins: got dv=%b drd=%h terr=%b want 1/5555aaaa/0", d_valid, d_rdata, timeout_err);
        end
        d_req = 1'b0; mem_ack = 1'b0;
        tick();

        d_req = 1'b1; d_addr = 32'h204;
        tick();
        n = 0;
        while (mem_req === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n != TO) begin
            n_bad++; $display("FAIL timeout_len: got %0d xfer cycles want %0d", n, TO);
        end
        n_cmp++;
        if (d_valid !== 1'b1 || d_rdata !== 32'h0 || timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_resp: got dv=%b drd=%h terr=%b want 1/0/1", d_valid, d_rdata, timeout_err);
        end
        d_req = 1'b0;
        tick();
        n_cmp++;
        if (d_valid !== 1'b0 || timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_sticky: got dv=%b terr=%b want 0/1", d_valid, timeout_err);
        end
        if_req = 1'b1; if_addr = 32'h30;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        n_cmp++;
        if (if_valid !== 1'b1 || if_rdata !== 32'h0BAD_F00D || timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_good_fetch: got iv=%b ird=%h terr=%b want 1/0badf00d/1", if_valid, if_rdata, timeout_err);
        end
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        if_req = 1'b1; if_addr = 32'h44;
        tick(); tick();
        n_cmp++;
        if (mem_req !== 1'b1 || timeout_err !== 1'b1) begin
            n_bad++; $display("FAIL midrst_pre: got req=%b terr=%b want 1/1", mem_req, timeout_err);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL midrst_abort: got req=%b iv=%b dv=%b terr=%b want 0/0/0/0", mem_req, if_valid, d_valid, timeout_err);
        end
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777; if_req = 1'b0;
        tick();
        reset = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0 || if_rdata !== 32'h0) begin
                n_bad++; $display("FAIL midrst_quiet%0d: got req=%b iv=%b dv=%b ird=%h want 0/0/0/0", i, mem_req, if_valid, d_valid, if_rdata);
            end
        end
    endtask

    task automatic test_random_traffic(input int ncyc);
        logic [31:0] ref_mem [16];
        logic [31:0] bus_mem [16];
        int    ph, xfer_n, ack_at;
        bit    pred_grant, pred_who, last_who, cur_who, ack_sent, drop_if, drop_d, drained;
        logic [31:0] exp_addr, exp_wdata, exp_if_rd, exp_d_rd;
        logic  exp_we, exp_ifv, exp_dv, exp_stall;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            bus_mem[i] = ref_mem[i];
        end
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        reset = 1'b1;
        ph = 0; xfer_n = 0; ack_at = 0;
        pred_grant = 0; pred_who = 0; last_who = 0; cur_who = 0; ack_sent = 0; drained = 0;
        exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; exp_if_rd = '0; exp_d_rd = '0;

        for (int cyc = 0; cyc < ncyc + 300; cyc++) begin
            tick();
            exp_ifv = 1'b0; exp_dv = 1'b0; drop_if = 0; drop_d = 0;
            // ph: 0 = arbiter idle this cycle, 1 = transfer in flight, 2 = response cycle.
            if (ph == 0) begin
                if (pred_grant) begin
                    n_cmp++;
                    if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wdata)) begin
                        n_bad++; $display("FAIL rnd_grant@%0d: got req=%b addr=%h we=%b wd=%h want 1/%h/%b/%h", cyc, mem_req, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wdata);
                    end
                    ph = 1; cur_who = pred_who; last_who = pred_who;
                    xfer_n = 0; ack_at = $urandom_range(0, 4); ack_sent = 0;
                end else begin
                    n_cmp++;
                    if (mem_req !== 1'b0) begin
                        n_bad++; $display("FAIL rnd_idle@%0d: got req=%b want 0", cyc, mem_req);
                    end
                end
            end else if (ph == 1) begin
                if (ack_sent) begin
                    ph = 2;
                    if (cur_who) begin
                        exp_dv = 1'b1;
                        if (exp_we) ref_mem[exp_addr[5:2]] = exp_wdata;
                        else exp_d_rd = ref_mem[exp_addr[5:2]];
                    end else begin
                        exp_ifv = 1'b1;
                        exp_if_rd = ref_mem[exp_addr[5:2]];
                    end
                    n_cmp++;
                    if (mem_req !== 1'b0) begin
                        n_bad++; $display("FAIL rnd_release@%0d: got req=%b want 0", cyc, mem_req);
                    end
                end else begin
                    xfer_n++;
                    n_cmp++;
                    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
                        n_bad++; $display("FAIL rnd_hold@%0d: got req=%b addr=%h want 1/%h", cyc, mem_req, mem_addr, exp_addr);
                    end
                end
            end else begin
                ph = 0;
                n_cmp++;
                if (mem_req !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_turnaround@%0d: got req=%b want 0", cyc, mem_req);
                end
            end

            n_cmp++;
            if (if_valid !== exp_ifv || d_valid !== exp_dv) begin
                n_bad++; $display("FAIL rnd_valid@%0d: got iv=%b dv=%b want %b/%b", cyc, if_valid, d_valid, exp_ifv, exp_dv);
            end
            n_cmp++;
            if (if_rdata !== exp_if_rd || d_rdata !== exp_d_rd) begin
                n_bad++; $display("FAIL rnd_rdata@%0d: got ird=%h drd=%h want %h/%h", cyc, if_rdata, d_rdata, exp_if_rd, exp_d_rd);
            end
            exp_stall = (if_req && !exp_ifv) || (d_req && !exp_dv);
            n_cmp++;
            if (stall !== exp_stall || timeout_err !== 1'b0) begin
                n_bad++; $display("FAIL rnd_stall@%0d: got stall=%b terr=%b want %b/0", cyc, stall, timeout_err, exp_stall);
            end

            if (exp_ifv) begin if_req = 1'b0; drop_if = 1; end
            if (exp_dv)  begin d_req  = 1'b0; drop_d  = 1; end

            mem_ack = 1'b0;
            if (ph == 1 && !ack_sent && xfer_n == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = bus_mem[mem_addr[5:2]];
                if (mem_we) bus_mem[mem_addr[5:2]] = mem_wdata;
                ack_sent = 1;
            end else if (ph != 1 && $urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = $urandom;
            end

            if (cyc < ncyc) begin
                if (!if_req && !drop_if && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1;
                    if_addr = 32'($urandom_range(0, 15)) << 2;
                end
                if (!d_req && !drop_d && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1;
                    d_we = 1'($urandom_range(0, 1));
                    d_addr = 32'($urandom_range(0, 15)) << 2;
                    d_wdata = $urandom;
                end
            end

            pred_grant = 0;
            if (ph == 0 && (if_req || d_req)) begin
                pred_grant = 1;
                pred_who = (if_req && d_req) ? !last_who : d_req;
                if (pred_who) begin
                    exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata;
                end else begin
                    exp_addr = if_addr; exp_we = 1'b0; exp_wdata = '0;
                end
            end

            if (cyc >= ncyc && ph == 0 && !if_req && !d_req) begin
                drained = 1;
                break;
            end
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (!drained) begin
            n_bad++; $display("FAIL rnd_drain: got drained=%b want 1", drained);
        end
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_single_fetch();
        test_tie_round_robin();
        test_timeout();
        test_mid_reset();
        test_random_traffic(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the datapath's instruction fetch (PC) and its load/store access (ALUResult/WriteData/ReadData).
- Sequences each access as a request/ack transaction to the memory.
- Returns read data to the winning requester and drives a stall that freezes the PC register until both pending accesses complete.
- Sits between Data_Path and the unified memory.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- TIMEOUT_CYC, 15, cycles waited for mem_ack before aborting a transaction (1..255)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous reset, active-low: state resets on a rising CLK edge while reset==0
- if_req  input  1  fetch request; held high until if_valid
- if_addr  input  ADDR_W  fetch address (PC)
- if_rdata  output  DATA_W  fetched instruction, registered
- if_valid  output  1  one-cycle pulse: fetch complete, if_rdata valid
- d_req  input  1  data request; held high until d_valid
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address (ALUResult)
- d_wdata  input  DATA_W  store data (WriteData)
- d_rdata  output  DATA_W  load data (ReadData), registered
- d_valid  output  1  one-cycle pulse: data access complete
- mem_req  output  1  memory transaction request, registered
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_W  memory address, registered
- mem_wdata  output  DATA_W  memory write data, registered
- mem_rdata  input  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  input  1  memory completes the current transaction this cycle
- stall  output  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid)
- timeout_err  output  1  sticky flag: an access timed out

Behaviour:
- Reset values:
  - state=IDLE; last_grant=FETCH.
  - mem_req, mem_we, if_valid, d_valid, timeout_err = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - timeout counter = 0.
- Reset is honoured in any state, including mid-transaction: mem_req drops on the next edge and no valid pulse is issued for the aborted access.
- IDLE: requests are sampled here only.
  - Only d_req: grant DATA.
  - Only if_req: grant FETCH.
  - Both: grant opposite of last_grant (round-robin). Reset last_grant=FETCH, so data wins the first tie.
  - On grant, on the same edge: register mem_addr; mem_we=d_we for DATA, 0 for FETCH; mem_wdata=d_wdata for DATA; mem_req=1; counter=0; last_grant updated; go to XFER.
- XFER: mem_req, mem_we, mem_addr, mem_wdata held stable.
  - mem_ack=1:
    - Capture mem_rdata into if_rdata (FETCH) or d_rdata (DATA load).
    - Store: d_rdata unchanged.
    - mem_req=0; go to RESP.
  - mem_ack=0: counter+1.
    - When counter reaches TIMEOUT_CYC-1 with no ack: mem_req=0, timeout_err=1, the granted rdata register is loaded with 0, go to RESP. Ack and timeout in the same cycle: ack wins.
- RESP: exactly one cycle.
  - if_valid=1 (FETCH) or d_valid=1 (DATA); mem_req=0; next state IDLE.
  - The requester must drop its req on the edge that ends RESP. A req still high in IDLE is treated as a new request.
- Latency:
  - Request seen in IDLE at edge n -> mem_req high from n.
  - Ack sampled at edge m -> valid high during cycle m..m+1.
  - Minimum request-to-valid = 2 cycles; one turnaround IDLE cycle between back-to-back transactions.
- mem_ack outside XFER is ignored.
- Request inputs changing while not in IDLE are ignored, except for the stall computation.
- timeout_err clears only on reset.

Test Plan:
- Reset: hold reset=0 two cycles with if_req=1 -> all outputs 0, state IDLE; release -> mem_req=1, mem_addr=if_addr the next edge.
- Single fetch: if_addr=0x00000008, mem_ack after 3 cycles with mem_rdata=0xE3A01005 -> if_rdata=0xE3A01005, if_valid pulses exactly 1 cycle, stall high until that cycle.
- Tie: if_req and d_req both high from reset, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, ack immediate -> DATA first (mem_we=1, mem_wdata=0xDEADBEEF), d_valid, then FETCH; d_rdata stays 0.
- Round-robin: three successive ties -> grant order DATA, FETCH, DATA.
- Timeout: TIMEOUT_CYC=15, d_req load with no ack -> mem_req drops after 15 XFER cycles, d_valid pulses, d_rdata=0, timeout_err=1 and stays 1 through a later good fetch.
- Mid-transaction reset: reset=0 during XFER -> mem_req=0 next edge, no if_valid/d_valid pulse, timeout_err cleared.
